sdio_host_data_phy: RTL and testbench
=====================================

// Module: sdio_host_data_phy
// PURPOSE
//  Host-side 4-bit SD/SDIO DAT-line engine: the opposite end of the card data PHY.
//  Write: serialises a byte block onto DAT[3:0] with start bit, CRC16 per line and
//  end bit, then collects the card's CRC status token and waits out busy.
//  Read: waits for the card start bit, deserialises nibbles into bytes, checks CRC16 per line.
//  Sits between the host command/transaction controller and the FPGA pad/IOB logic.
//  One DAT bit time per clk cycle (SDR).
// PARAMETERS
//  RD_TIMEOUT    16'hFFFF  max cycles to wait for read start bit or write CRC-status start bit
//  BUSY_TIMEOUT  16'hFFFF  max cycles DAT0 may be held low (busy) after a write
// PORTS
//  clk              in   1   clock; one cycle = one SD bit time
//  rst              in   1   reset, asynchronous, active-high
//  i_activate       in   1   level; high runs one block transfer, low aborts/returns to IDLE
//  i_write_flag     in   1   1 = host-to-card write, 0 = card-to-host read; sampled in IDLE
//  i_data_count     in   13  block length in bytes (1..4096); sampled in IDLE
//  o_finished       out  1   high in FINISHED until i_activate drops
//  o_data_rd_stb    out  1   write path: one-cycle request for the next byte
//  i_data_rd_data   in   8   write path: byte, valid the cycle after o_data_rd_stb
//  i_data_rdy       in   1   write path: source holds >= 1 byte
//  o_data_wr_stb    out  1   read path: one-cycle strobe, o_data_wr_data valid
//  o_data_wr_data   out  8   read path: assembled byte
//  o_crc_good       out  1   read: all four line CRCs matched and end bit = 4'hF; write: status == 3'b010
//  o_crc_status     out  3   write: CRC status token bits captured from DAT0
//  o_timeout        out  1   start-bit, status or busy timeout occurred
//  o_sd_data_dir    out  1   1 = host drives DAT[3:0]
//  o_sd_data_out    out  4   DAT[3:0] drive value
//  i_sd_data_in     in   4   DAT[3:0] sampled value
// BEHAVIOUR
//  Reset: o_sd_data_dir=0, o_sd_data_out=4'hF, all strobes 0, o_finished=0, o_crc_good=0,
//   o_crc_status=0, o_timeout=0, o_data_wr_data=0, state=IDLE.
//  CRC: CRC16-CCITT (x^16+x^12+x^5+1), init 0, one instance per DAT line, covers data bits only.
//  Nibble order: byte[7:4] first on DAT[3:0], then byte[3:0]; CRC sent/received MSB first.
//  IDLE: dir=0, out=F; i_activate -> clear outputs, latch count/flag -> WR_WAIT or RD_WAIT.
//  WR_WAIT: when i_data_rdy, pulse o_data_rd_stb (prefetch byte 0) -> WR_START.
//  WR_START: dir=1, out=4'h0 for 1 cycle -> WR_DATA.
//  WR_DATA: 2*count cycles driving nibbles; o_data_rd_stb pulses on each high-nibble cycle
//   except the last byte; source must supply on time (no underflow handling) -> WR_CRC.
//  WR_CRC: 16 cycles, out[n]=crc[n][15-k] -> WR_END: out=4'hF 1 cycle, then dir=0 -> WR_STAT.
//  WR_STAT: wait DAT0=0 (start), then capture 3 bits into o_crc_status, then 1 end bit;
//   no start within RD_TIMEOUT -> o_timeout=1, FINISHED. Status captured -> WR_BUSY.
//  WR_BUSY: wait DAT0=1; o_crc_good=(status==3'b010); > BUSY_TIMEOUT cycles -> o_timeout=1.
//  RD_WAIT: dir=0; wait i_sd_data_in==4'h0 (all four lines); RD_TIMEOUT -> o_timeout, FINISHED.
//  RD_DATA: 2*count nibbles; o_data_wr_stb pulses the cycle after each low nibble is sampled.
//  RD_CRC: 16 cycles shift received CRC per line -> RD_END: sample end bits;
//   o_crc_good = all 4 CRCs equal computed AND end == 4'hF -> FINISHED.
//  FINISHED: o_finished=1, dir=0, out=F; i_activate low -> IDLE (results held until next start).
//  i_activate low in any state: next cycle IDLE, dir=0, out=F, no further strobes, no o_finished.
//  Partial start bit on read (some lines 0, not all) is ignored; keep waiting.
//  i_data_count=0: treated as 4096.
// TESTING
//  Write 4 bytes 8'h00: DAT=F,0, then 8 cycles 0, 16 cycles 0 (CRC=0), F; dir falls; 4 rd_stb pulses.
//  Write 512 bytes ramp, card returns status 010 then busy 20 cycles -> o_crc_good=1, o_finished=1.
//  Card returns status 101 -> o_crc_status=3'b101, o_crc_good=0, o_finished=1.
//  Read 512 bytes from bench card model, correct CRCs -> 512 wr_stb, data matches, o_crc_good=1.
//  Read with one CRC bit flipped on DAT2 -> o_crc_good=0; no start bit within RD_TIMEOUT -> o_timeout=1.
//  Drop i_activate mid WR_DATA and mid RD_DATA -> IDLE next cycle, dir=0, out=F; async rst mid-block -> reset values.

Source files
------------

// File: rtl/sdio_host_data_phy.sv
// Host-side 4-bit SD DAT engine: block write (start, nibbles, CRC16 per line, end, status, busy) and block read.
// All outputs registered, so pins follow the state by one clk; the byte source answers o_data_rd_stb one cycle later.
module sdio_host_data_phy #(
    parameter logic [15:0] RD_TIMEOUT   = 16'hFFFF,
    parameter logic [15:0] BUSY_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_activate,
    input  logic        i_write_flag,
    input  logic [12:0] i_data_count,
    output logic        o_finished,
    output logic        o_data_rd_stb,
    input  logic [7:0]  i_data_rd_data,
    input  logic        i_data_rdy,
    output logic        o_data_wr_stb,
    output logic [7:0]  o_data_wr_data,
    output logic        o_crc_good,
    output logic [2:0]  o_crc_status,
    output logic        o_timeout,
    output logic        o_sd_data_dir,
    output logic [3:0]  o_sd_data_out,
    input  logic [3:0]  i_sd_data_in
);
    typedef enum logic [3:0] {
        IDLE, WR_WAIT, WR_START, WR_DATA, WR_CRC, WR_END, WR_STAT, WR_BUSY,
        RD_WAIT, RD_DATA, RD_CRC, RD_END, FINISHED
    } state_t;

    state_t      state;
    logic [13:0] nib_cnt;
    logic [13:0] nib_last;
    logic [3:0]  bit_cnt;
    logic [15:0] tmo_cnt;
    logic [3:0]  held_nib;
    logic [15:0] crc    [4];
    logic [15:0] rx_crc [4];
    logic [3:0]  crc_in;
    logic        crc_match;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Write: high nibble comes straight from the freshly fetched byte, low nibble from the held copy.
    always_comb begin
        crc_in = nib_cnt[0] ? held_nib : i_data_rd_data[7:4];
        if (state == RD_DATA) crc_in = i_sd_data_in;
        crc_match = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (rx_crc[n] != crc[n]) crc_match = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            o_sd_data_dir  <= 1'b0;
            o_sd_data_out  <= 4'hF;
            o_data_rd_stb  <= 1'b0;
            o_data_wr_stb  <= 1'b0;
            o_data_wr_data <= 8'h00;
            o_finished     <= 1'b0;
            o_crc_good     <= 1'b0;
            o_crc_status   <= 3'b000;
            o_timeout      <= 1'b0;
            nib_cnt        <= 14'd0;
            nib_last       <= 14'd0;
            bit_cnt        <= 4'd0;
            tmo_cnt        <= 16'd0;
            held_nib       <= 4'h0;
            for (int n = 0; n < 4; n++) begin
                crc[n]    <= 16'h0000;
                rx_crc[n] <= 16'h0000;
            end
        end else begin
            o_data_rd_stb <= 1'b0;
            o_data_wr_stb <= 1'b0;
            if (!i_activate && state != IDLE) begin
                state         <= IDLE;
                o_sd_data_dir <= 1'b0;
                o_sd_data_out <= 4'hF;
                o_finished    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        o_sd_data_dir <= 1'b0;
                        o_sd_data_out <= 4'hF;
                        o_finished    <= 1'b0;
                        if (i_activate) begin
                            o_crc_good   <= 1'b0;
                            o_crc_status <= 3'b000;
                            o_timeout    <= 1'b0;
                            nib_cnt      <= 14'd0;
                            bit_cnt      <= 4'd0;
                            tmo_cnt      <= 16'd0;
                            nib_last     <= (i_data_count == 13'd0) ? 14'd8191
                                                                    : {i_data_count, 1'b0} - 14'd1;
                            for (int n = 0; n < 4; n++) begin
                                crc[n]    <= 16'h0000;
                                rx_crc[n] <= 16'h0000;
                            end
                            state <= i_write_flag ? WR_WAIT : RD_WAIT;
                        end
                    end
                    WR_WAIT: begin
                        if (i_data_rdy) begin
                            o_data_rd_stb <= 1'b1;
                            state         <= WR_START;
                        end
                    end
                    WR_START: begin
                        o_sd_data_dir <= 1'b1;
                        o_sd_data_out <= 4'h0;
                        state         <= WR_DATA;
                    end
                    WR_DATA: begin
                        o_sd_data_out <= crc_in;
                        for (int n = 0; n < 4; n++) crc[n] <= crc_step(crc[n], crc_in[n]);
                        if (!nib_cnt[0]) begin
                            held_nib <= i_data_rd_data[3:0];
                            if (nib_cnt != nib_last - 14'd1) o_data_rd_stb <= 1'b1;
                        end
                        nib_cnt <= nib_cnt + 14'd1;
                        if (nib_cnt == nib_last) begin
                            bit_cnt <= 4'd0;
                            state   <= WR_CRC;
                        end
                    end
                    WR_CRC: begin
                        for (int n = 0; n < 4; n++) begin
                            o_sd_data_out[n] <= crc[n][15];
                            crc[n]           <= {crc[n][14:0], 1'b0};
                        end
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) state <= WR_END;
                    end
                    WR_END: begin
                        o_sd_data_out <= 4'hF;
                        bit_cnt       <= 4'd0;
                        tmo_cnt       <= 16'd0;
                        state         <= WR_STAT;
                    end
                    // bit_cnt: 0 = hunting start bit, 1..3 = status bits, 4 = end bit
                    WR_STAT: begin
                        o_sd_data_dir <= 1'b0;
                        o_sd_data_out <= 4'hF;
                        if (bit_cnt == 4'd0) begin
                            if (!i_sd_data_in[0]) begin
                                bit_cnt <= 4'd1;
                            end else if (tmo_cnt == RD_TIMEOUT) begin
                                o_timeout <= 1'b1;
                                state     <= FINISHED;
                            end else begin
                                tmo_cnt <= tmo_cnt + 16'd1;
                            end
                        end else if (bit_cnt < 4'd4) begin
                            o_crc_status <= {o_crc_status[1:0], i_sd_data_in[0]};
                            bit_cnt      <= bit_cnt + 4'd1;
                        end else begin
                            tmo_cnt <= 16'd0;
                            state   <= WR_BUSY;
                        end
                    end
                    WR_BUSY: begin
                        if (i_sd_data_in[0]) begin
                            o_crc_good <= (o_crc_status == 3'b010);
                            state      <= FINISHED;
                        end else if (tmo_cnt == BUSY_TIMEOUT) begin
                            o_crc_good <= (o_crc_status == 3'b010);
                            o_timeout  <= 1'b1;
                            state      <= FINISHED;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    RD_WAIT: begin
                        o_sd_data_dir <= 1'b0;
                        o_sd_data_out <= 4'hF;
                        if (i_sd_data_in == 4'h0) begin
                            nib_cnt <= 14'd0;
                            state   <= RD_DATA;
                        end else if (tmo_cnt == RD_TIMEOUT) begin
                            o_timeout <= 1'b1;
                            state     <= FINISHED;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    RD_DATA: begin
                        for (int n = 0; n < 4; n++) crc[n] <= crc_step(crc[n], crc_in[n]);
                        if (!nib_cnt[0]) begin
                            held_nib <= i_sd_data_in;
                        end else begin
                            o_data_wr_data <= {held_nib, i_sd_data_in};
                            o_data_wr_stb  <= 1'b1;
                        end
                        nib_cnt <= nib_cnt + 14'd1;
                        if (nib_cnt == nib_last) begin
                            bit_cnt <= 4'd0;
                            state   <= RD_CRC;
                        end
                    end
                    RD_CRC: begin
                        for (int n = 0; n < 4; n++) rx_crc[n] <= {rx_crc[n][14:0], i_sd_data_in[n]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) state <= RD_END;
                    end
                    RD_END: begin
                        o_crc_good <= crc_match && (i_sd_data_in == 4'hF);
                        state      <= FINISHED;
                    end
                    FINISHED: begin
                        o_finished    <= 1'b1;
                        o_sd_data_dir <= 1'b0;
                        o_sd_data_out <= 4'hF;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdio_host_data_phy.sv
// Bench for sdio_host_data_phy: byte source and card model driven at negedge, CRC reference by polynomial division.
module tb_sdio_host_data_phy;
    localparam logic [15:0] RD_TMO   = 16'd300;
    localparam logic [15:0] BUSY_TMO = 16'd300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_activate = 1'b0;
    logic        i_write_flag = 1'b0;
    logic [12:0] i_data_count = 13'd0;
    logic        o_finished;
    logic        o_data_rd_stb;
    logic [7:0]  i_data_rd_data = 8'h00;
    logic        i_data_rdy = 1'b0;
    logic        o_data_wr_stb;
    logic [7:0]  o_data_wr_data;
    logic        o_crc_good;
    logic [2:0]  o_crc_status;
    logic        o_timeout;
    logic        o_sd_data_dir;
    logic [3:0]  o_sd_data_out;
    logic [3:0]  i_sd_data_in = 4'hF;

    always #5 clk = ~clk;

    sdio_host_data_phy #(.RD_TIMEOUT(RD_TMO), .BUSY_TIMEOUT(BUSY_TMO)) dut (
        .clk(clk), .rst(rst), .i_activate(i_activate), .i_write_flag(i_write_flag),
        .i_data_count(i_data_count), .o_finished(o_finished), .o_data_rd_stb(o_data_rd_stb),
        .i_data_rd_data(i_data_rd_data), .i_data_rdy(i_data_rdy), .o_data_wr_stb(o_data_wr_stb),
        .o_data_wr_data(o_data_wr_data), .o_crc_good(o_crc_good), .o_crc_status(o_crc_status),
        .o_timeout(o_timeout), .o_sd_data_dir(o_sd_data_dir), .o_sd_data_out(o_sd_data_out),
        .i_sd_data_in(i_sd_data_in)
    );

    typedef struct {
        int         wr;
        int         nbytes;   // 0 means 4096
        int         pat;      // 0 zeros, 1 ramp, 2 random
        logic [2:0] status;
        int         busy;
        int         flip;
        int         nostart;
        int         partial;
        int         exp_good;
        int         exp_tmo;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         src_idx = 0;
    int         stb_cnt = 0;
    logic [7:0] dbuf [0:4095];
    logic [3:0] stream_q[$];
    logic [3:0] cap_q[$];
    logic [3:0] card_q[$];
    logic [7:0] rx_q[$];
    vec_t       vecs [0:9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^16 mod G(x) for one DAT line's bit sequence.
    function automatic logic [15:0] ref_crc(input int nb, input int line);
        logic [16:0] r;
        logic        b;
        r = 17'd0;
        for (int i = 0; i < nb * 2 + 16; i++) begin
            if (i < nb * 2) b = (i % 2 == 0) ? dbuf[i / 2][4 + line] : dbuf[i / 2][line];
            else            b = 1'b0;
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic build_block(input int nb, input int flip);
        logic [15:0] c [4];
        for (int l = 0; l < 4; l++) c[l] = ref_crc(nb, l);
        if (flip != 0) c[2][10] = ~c[2][10];
        stream_q.delete();
        for (int i = 0; i < nb; i++) begin
            stream_q.push_back(dbuf[i][7:4]);
            stream_q.push_back(dbuf[i][3:0]);
        end
        for (int k = 0; k < 16; k++)
            stream_q.push_back({c[3][15 - k], c[2][15 - k], c[1][15 - k], c[0][15 - k]});
    endtask

    task automatic tick();
        @(negedge clk);
        if (o_data_rd_stb) begin
            i_data_rd_data = dbuf[src_idx[11:0]];
            src_idx++;
            stb_cnt++;
        end
        if (o_data_wr_stb) rx_q.push_back(o_data_wr_data);
        i_sd_data_in = (card_q.size() != 0) ? card_q.pop_front() : 4'hF;
    endtask

    task automatic start_txn(input int wr, input int nbytes, input int pat);
        int nb;
        nb = (nbytes == 0) ? 4096 : nbytes;
        for (int i = 0; i < nb; i++)
            dbuf[i] = (pat == 0) ? 8'h00 : (pat == 1) ? 8'(i) : 8'($urandom);
        src_idx = 0; stb_cnt = 0;
        cap_q.delete(); rx_q.delete(); card_q.delete();
        @(negedge clk);
        i_write_flag = (wr != 0);
        i_data_count = 13'(nbytes);
        i_data_rdy   = 1'b1;
        i_activate   = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        int nb, mism, seen, done, fin, dir_seen;
        logic [3:0] e;
        nb = (v.nbytes == 0) ? 4096 : v.nbytes;
        start_txn(v.wr, v.nbytes, v.pat);
        build_block(nb, v.flip);
        fin = 0;
        if (v.wr != 0) begin
            seen = 0; done = 0;
            for (int c = 0; c < 20000 && done == 0; c++) begin
                tick();
                if (o_sd_data_dir) begin seen = 1; cap_q.push_back(o_sd_data_out); end
                else if (seen != 0) done = 1;
            end
            check("wr_dir_released", done, 1);
            check("wr_rd_stb_count", stb_cnt, nb);
            check("wr_stream_len", cap_q.size(), nb * 2 + 18);
            mism = 0;
            for (int i = 0; i < cap_q.size() && i < nb * 2 + 18; i++) begin
                if (i == 0)               e = 4'h0;
                else if (i == nb * 2 + 17) e = 4'hF;
                else                      e = stream_q[i - 1];
                if (cap_q[i] !== e) mism++;
            end
            check("wr_stream_nibbles", mism, 0);
            if (v.nostart == 0) begin
                card_q.push_back(4'hF);
                card_q.push_back(4'hE);
                for (int b = 2; b >= 0; b--) card_q.push_back({3'b111, v.status[b]});
                card_q.push_back(4'hF);
                for (int b = 0; b < v.busy; b++) card_q.push_back(4'hE);
            end
            for (int c = 0; c < 2000 && fin == 0; c++) begin
                tick();
                fin = int'(o_finished);
            end
            check("wr_crc_status", int'(o_crc_status), (v.nostart != 0) ? 0 : int'(v.status));
        end else begin
            for (int d = 0; d < int'($urandom_range(1, 6)); d++) card_q.push_back(4'hF);
            if (v.partial != 0) begin card_q.push_back(4'b1010); card_q.push_back(4'hF); end
            if (v.nostart == 0) begin
                card_q.push_back(4'h0);
                foreach (stream_q[i]) card_q.push_back(stream_q[i]);
                card_q.push_back(4'hF);
            end
            dir_seen = 0;
            for (int c = 0; c < 20000 && fin == 0; c++) begin
                tick();
                if (o_sd_data_dir) dir_seen = 1;
                fin = int'(o_finished);
            end
            check("rd_dir_low", dir_seen, 0);
            check("rd_byte_count", rx_q.size(), (v.nostart != 0) ? 0 : nb);
            mism = 0;
            for (int i = 0; i < rx_q.size() && i < nb; i++) if (rx_q[i] !== dbuf[i]) mism++;
            check("rd_data", mism, 0);
        end
        check("finished", fin, 1);
        check("timeout", int'(o_timeout), v.exp_tmo);
        check("crc_good", int'(o_crc_good), v.exp_good);
        i_activate = 1'b0;
        tick();
        check("finished_drop", int'(o_finished), 0);
        card_q.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int wait_ok;
        vecs[0] = '{1, 4,   0, 3'b010, 0,  0, 0, 0, 1, 0};
        vecs[1] = '{1, 512, 1, 3'b010, 20, 0, 0, 0, 1, 0};
        vecs[2] = '{1, 16,  2, 3'b101, 3,  0, 0, 0, 0, 0};
        vecs[3] = '{1, 8,   2, 3'b010, 0,  0, 1, 0, 0, 1};
        vecs[4] = '{0, 512, 1, 3'b000, 0,  0, 0, 0, 1, 0};
        vecs[5] = '{0, 64,  2, 3'b000, 0,  1, 0, 0, 0, 0};
        vecs[6] = '{0, 1,   2, 3'b000, 0,  0, 1, 0, 0, 1};
        vecs[7] = '{0, 32,  2, 3'b000, 0,  0, 0, 1, 1, 0};
        vecs[8] = '{1, 1,   2, 3'b010, 5,  0, 0, 0, 1, 0};
        vecs[9] = '{0, 0,   2, 3'b000, 0,  0, 0, 0, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_dir", int'(o_sd_data_dir), 0);
        check("rst_out", int'(o_sd_data_out), 15);
        check("rst_strobes", int'({o_data_rd_stb, o_data_wr_stb}), 0);
        check("rst_flags", int'({o_finished, o_crc_good, o_timeout}), 0);
        check("rst_status", int'(o_crc_status), 0);
        check("rst_wr_data", int'(o_data_wr_data), 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 10; t++) run_txn(vecs[t]);

        for (int r = 0; r < 6; r++) begin
            v.wr      = int'($urandom_range(0, 1));
            v.nbytes  = int'($urandom_range(1, 40));
            v.pat     = 2;
            v.status  = 3'($urandom_range(0, 7));
            v.busy    = int'($urandom_range(0, 10));
            v.flip    = (v.wr != 0) ? 0 : int'($urandom_range(0, 1));
            v.nostart = 0;
            v.partial = (v.wr != 0) ? 0 : int'($urandom_range(0, 1));
            v.exp_good = (v.wr != 0) ? int'(v.status == 3'b010) : int'(v.flip == 0);
            v.exp_tmo  = 0;
            run_txn(v);
        end

        // Abort in the middle of write data.
        start_txn(1, 32, 2);
        wait_ok = 0;
        for (int c = 0; c < 50 && wait_ok == 0; c++) begin tick(); wait_ok = int'(o_sd_data_dir); end
        repeat (10) tick();
        check("abort_wr_active", int'(o_sd_data_dir), 1);
        i_activate = 1'b0;
        tick();
        check("abort_wr_dir", int'(o_sd_data_dir), 0);
        check("abort_wr_out", int'(o_sd_data_out), 15);
        stb_cnt = 0; wait_ok = 0;
        for (int c = 0; c < 6; c++) begin tick(); wait_ok += int'(o_sd_data_dir) + int'(o_finished); end
        check("abort_wr_quiet", stb_cnt + wait_ok, 0);

        // Abort in the middle of read data.
        start_txn(0, 32, 2);
        card_q.push_back(4'hF); card_q.push_back(4'hF); card_q.push_back(4'h0);
        for (int i = 0; i < 40; i++) card_q.push_back(4'($urandom));
        repeat (12) tick();
        check("abort_rd_active", int'(rx_q.size() > 0), 1);
        i_activate = 1'b0;
        tick();
        check("abort_rd_dir_out", int'({o_sd_data_dir, o_sd_data_out}), 15);
        rx_q.delete(); wait_ok = 0;
        for (int c = 0; c < 6; c++) begin tick(); wait_ok += int'(o_finished); end
        check("abort_rd_quiet", rx_q.size() + wait_ok, 0);
        card_q.delete();

        // Asynchronous reset in the middle of a write block.
        start_txn(1, 64, 2);
        wait_ok = 0;
        for (int c = 0; c < 50 && wait_ok == 0; c++) begin tick(); wait_ok = int'(o_sd_data_dir); end
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_dir", int'(o_sd_data_dir), 0);
        check("arst_out", int'(o_sd_data_out), 15);
        check("arst_flags", int'({o_data_rd_stb, o_finished, o_crc_good, o_timeout}), 0);
        i_activate = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        v = '{1, 6, 2, 3'b010, 2, 0, 0, 0, 1, 0};
        run_txn(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
